keypad_scan_input: RTL



---
 rtl/keypad_pkg.sv | 65 ++++++
 rtl/scan_tick_gen.sv | 32 +++
 rtl/keypad_scan_input.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad scanner and its tick generator.
//   - FSM state encodings (SCAN, DEBOUNCE, HOLD)
//   - rear-light mode words and the key-to-mode mapping
//   - row drive reset pattern and small helpers for the row/column logic
package keypad_pkg;

  // FSM encoding
  localparam logic [1:0] SCAN     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;

  // Rear-light mode words (one-hot, or all-off)
  localparam logic [3:0] MODE_OFF = 4'b0000;
  localparam logic [3:0] MODE_A   = 4'b0001;
  localparam logic [3:0] MODE_B   = 4'b0010;
  localparam logic [3:0] MODE_C   = 4'b0100;
  localparam logic [3:0] MODE_D   = 4'b1000;

  // Row 0 driven low out of reset; columns read all-high when idle
  localparam logic [3:0] ROW_RESET = 4'b1110;
  localparam logic [3:0] COL_IDLE  = 4'b1111;

  // Scanner context kept together so the FSM state and the latched key
  // position can be observed as one signal.
  typedef struct packed {
    logic [1:0] state;
    logic [1:0] row_idx;
    logic [1:0] col_idx;
  } scan_ctx_t;

  // Keys 0..4 select a mode; every other key keeps the current one.
  function automatic logic [3:0] key_to_mode(input logic [3:0] code,
                                             input logic [3:0] cur);
    logic [3:0] m;
    m = cur;
    case (code)
      4'd0:    m = MODE_OFF;
      4'd1:    m = MODE_A;
      4'd2:    m = MODE_B;
      4'd3:    m = MODE_C;
      4'd4:    m = MODE_D;
      default: m = cur;
    endcase
    return m;
  endfunction

  // Index of the lowest-numbered low bit; used for both the active row
  // and the winning column when several columns are pulled low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (!v[0])      idx = 2'd0;
    else if (!v[1]) idx = 2'd1;
    else if (!v[2]) idx = 2'd2;
    else if (!v[3]) idx = 2'd3;
    return idx;
  endfunction

  // Move the single low row bit to the next row (1110 -> 1101 -> ...).
  function automatic logic [3:0] rotl(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
// Free-running divider producing a one-clk tick every CLK_DIV cycles.
// Shared with the display scan logic.
//   clk  : system clock
//   rst  : asynchronous active-low reset (divider returns to 0)
//   tick : high for one cycle when the divider reaches CLK_DIV-1
module scan_tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan_input.sv
// keypad_scan_input
// Scans a 4x4 key matrix, debounces presses and turns accepted keys into
// the rear-light mode word.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   key_col   : column returns, active-low, asynchronous to clk
//   key_row   : row drive, exactly one bit low
//   state_out : latched mode word (0000 / 0001 / 0010 / 0100 / 1000)
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-clk pulse per accepted press
module keypad_scan_input
  import keypad_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] state_out,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int            DW      = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS);

  // Two-flop synchronizer for the asynchronous column returns
  logic [3:0] col_meta;
  logic [3:0] col_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_meta <= COL_IDLE;
      col_s    <= COL_IDLE;
    end else begin
      col_meta <= key_col;
      col_s    <= col_meta;
    end
  end

  logic tick;

  scan_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  scan_ctx_t     ctx;
  logic [DW-1:0] db_cnt;

  logic [DW-1:0] db_next;
  logic          col_idle;
  logic [1:0]    hit_col;
  logic [1:0]    cur_row;
  logic          held_low;
  logic [3:0]    accept_code;

  assign db_next  = db_cnt + DW'(1);
  assign col_idle = (col_s == COL_IDLE);
  assign hit_col  = low_index(col_s);
  assign cur_row  = low_index(key_row);
  assign held_low = ~col_s[ctx.col_idx];
  // In SCAN the accepted key is the one just found (DEBOUNCE_TICKS = 1);
  // otherwise it is the position latched on entry to DEBOUNCE.
  assign accept_code = (ctx.state == SCAN) ? {cur_row, hit_col}
                                           : {ctx.row_idx, ctx.col_idx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctx.state   <= SCAN;
      ctx.row_idx <= 2'd0;
      ctx.col_idx <= 2'd0;
      db_cnt      <= '0;
      key_row     <= ROW_RESET;
      state_out   <= MODE_OFF;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (ctx.state)
          SCAN: begin
            if (col_idle) begin
              key_row <= rotl(key_row);
            end else begin
              // Row stays frozen on the pressed key's row from here on.
              ctx.row_idx <= cur_row;
              ctx.col_idx <= hit_col;
              if (DEBOUNCE_TICKS == 1) begin
                key_valid <= 1'b1;
                key_code  <= accept_code;
                state_out <= key_to_mode(accept_code, state_out);
                ctx.state <= HOLD;
                db_cnt    <= '0;
              end else begin
                ctx.state <= DEBOUNCE;
                db_cnt    <= DW'(1);
              end
            end
          end

          DEBOUNCE: begin
            if (held_low) begin
              if (db_next == DB_LAST) begin
                key_valid <= 1'b1;
                key_code  <= accept_code;
                state_out <= key_to_mode(accept_code, state_out);
                ctx.state <= HOLD;
                db_cnt    <= '0;
              end else begin
                db_cnt <= db_next;
              end
            end else begin
              // Bounce: drop the candidate and move on to the next row.
              key_row   <= rotl(key_row);
              ctx.state <= SCAN;
              db_cnt    <= '0;
            end
          end

          HOLD: begin
            // Any low column restarts the release count, so neither the
            // held key nor a second key can re-trigger.
            if (!col_idle) begin
              db_cnt <= '0;
            end else if (db_next == DB_LAST) begin
              key_row   <= rotl(key_row);
              ctx.state <= SCAN;
              db_cnt    <= '0;
            end else begin
              db_cnt <= db_next;
            end
          end

          default: begin
            ctx.state <= SCAN;
            db_cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule
